// File: rtl/matmul_tile_scheduler_if.sv
// Command, tile and status bundle between a job source and the tile scheduler.
// Latency: none, wires only.
// Backpressure: cmd_valid/cmd_ready for jobs, tile_valid/tile_ready for tiles.
interface matmul_tile_scheduler_if #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DIM_WIDTH      = 16,
  parameter int ID_WIDTH       = 4,
  parameter int JOB_FIFO_DEPTH = 4
);
  localparam int QW = $clog2(JOB_FIFO_DEPTH) + 1;

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [ID_WIDTH-1:0]   cmd_id;
  logic [DIM_WIDTH-1:0]  cmd_m;
  logic [DIM_WIDTH-1:0]  cmd_n;
  logic [DIM_WIDTH-1:0]  cmd_p;
  logic [ADDR_WIDTH-1:0] cmd_base_a;
  logic [ADDR_WIDTH-1:0] cmd_base_b;
  logic [ADDR_WIDTH-1:0] cmd_base_c;
  logic                  tile_valid;
  logic                  tile_ready;
  logic [ADDR_WIDTH-1:0] tile_a_addr;
  logic [ADDR_WIDTH-1:0] tile_b_addr;
  logic [ADDR_WIDTH-1:0] tile_c_addr;
  logic [DIM_WIDTH-1:0]  tile_rows;
  logic [DIM_WIDTH-1:0]  tile_cols;
  logic [DIM_WIDTH-1:0]  tile_n;
  logic                  tile_done_i;
  logic                  abort_i;
  logic                  job_done;
  logic                  job_err;
  logic [ID_WIDTH-1:0]   job_id_o;
  logic                  busy;
  logic [QW-1:0]         queued;

  // Job source / array side
  modport master (
    output cmd_valid, cmd_id, cmd_m, cmd_n, cmd_p, cmd_base_a, cmd_base_b, cmd_base_c,
    output tile_ready, tile_done_i, abort_i,
    input  cmd_ready, tile_valid, tile_a_addr, tile_b_addr, tile_c_addr,
    input  tile_rows, tile_cols, tile_n, job_done, job_err, job_id_o, busy, queued
  );

  // Scheduler side
  modport slave (
    input  cmd_valid, cmd_id, cmd_m, cmd_n, cmd_p, cmd_base_a, cmd_base_b, cmd_base_c,
    input  tile_ready, tile_done_i, abort_i,
    output cmd_ready, tile_valid, tile_a_addr, tile_b_addr, tile_c_addr,
    output tile_rows, tile_cols, tile_n, job_done, job_err, job_id_o, busy, queued
  );
endinterface

// File: rtl/matmul_tile_scheduler.sv
// Queues matrix jobs and splits each into ARRAY_HEIGHT x ARRAY_WIDTH output tiles, one in flight.
// Latency: push into empty queue -> tile_valid 3 cycles later; next tile 2 cycles after tile_done_i.
// Backpressure: cmd_ready low while the job FIFO is full; tile fields hold while tile_ready is low.
module matmul_tile_scheduler #(
  parameter int ARRAY_WIDTH      = 32,
  parameter int ARRAY_HEIGHT     = 4,
  parameter int DATA_WIDTH_BYTES = 1,
  parameter int ADDR_WIDTH       = 16,
  parameter int DIM_WIDTH        = 16,
  parameter int JOB_FIFO_DEPTH   = 4,
  parameter int ID_WIDTH         = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  matmul_tile_scheduler_if.slave bus
);
  localparam int PTR_W = $clog2(JOB_FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ROW_K = ARRAY_HEIGHT * DATA_WIDTH_BYTES;
  localparam logic [ADDR_WIDTH-1:0] B_COL_STEP = ADDR_WIDTH'(ARRAY_WIDTH * DATA_WIDTH_BYTES);
  localparam logic [ADDR_WIDTH-1:0] C_COL_STEP = ADDR_WIDTH'(ARRAY_WIDTH * 2 * DATA_WIDTH_BYTES);
  localparam logic [DIM_WIDTH-1:0]  TILE_H     = DIM_WIDTH'(ARRAY_HEIGHT);
  localparam logic [DIM_WIDTH-1:0]  TILE_W     = DIM_WIDTH'(ARRAY_WIDTH);
  localparam logic [CNT_W-1:0]      DEPTH_C    = CNT_W'(JOB_FIFO_DEPTH);

  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [DIM_WIDTH-1:0]  m;
    logic [DIM_WIDTH-1:0]  n;
    logic [DIM_WIDTH-1:0]  p;
    logic [ADDR_WIDTH-1:0] base_a;
    logic [ADDR_WIDTH-1:0] base_b;
    logic [ADDR_WIDTH-1:0] base_c;
  } job_t;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ISSUE, S_WAIT, S_NEXT} state_t;

  state_t                state_q, state_d;
  job_t                  fifo_mem [JOB_FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      count_q;
  job_t                  job_q;
  logic [ADDR_WIDTH-1:0] a_q, b_q, c_q, row_c_q;
  logic [DIM_WIDTH-1:0]  rem_m_q, rem_p_q;
  logic [ADDR_WIDTH-1:0] a_row_step, c_row_step;
  logic                  full, empty, push, pop, load, adv_col, adv_row;
  logic                  done_pulse, err_pulse, zero_dim, last_row, last_col;

  assign full     = (count_q == DEPTH_C);
  assign empty    = (count_q == '0);
  assign push     = bus.cmd_valid & ~full & ~bus.abort_i;
  assign zero_dim = (job_q.m == '0) | (job_q.n == '0) | (job_q.p == '0);
  assign last_row = (rem_m_q <= TILE_H);
  assign last_col = (rem_p_q <= TILE_W);

  // Job FIFO pointers and occupancy; abort flushes everything including a same-cycle push
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (bus.abort_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_q <= count_q + CNT_W'(1);
      else if (!push && pop) count_q <= count_q - CNT_W'(1);
    end
  end

  // Job FIFO storage (data only, no reset needed)
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= '{id: bus.cmd_id, m: bus.cmd_m, n: bus.cmd_n, p: bus.cmd_p,
                              base_a: bus.cmd_base_a, base_b: bus.cmd_base_b,
                              base_c: bus.cmd_base_c};
    end
  end

  // Row strides built as repeated additions of n and 2p (ROW_K adders, no multiplier)
  always_comb begin
    a_row_step = '0;
    c_row_step = '0;
    for (int k = 0; k < ROW_K; k++) begin
      a_row_step = a_row_step + ADDR_WIDTH'(job_q.n);
      c_row_step = c_row_step + ADDR_WIDTH'({job_q.p, 1'b0});
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // FSM next state and per-state control pulses; abort overrides every state
  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    load       = 1'b0;
    adv_col    = 1'b0;
    adv_row    = 1'b0;
    done_pulse = 1'b0;
    err_pulse  = 1'b0;
    if (bus.abort_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (!empty) begin
          pop     = 1'b1;
          state_d = S_LOAD;
        end
        S_LOAD: if (zero_dim) begin
          err_pulse = 1'b1;
          state_d   = S_IDLE;
        end else begin
          load    = 1'b1;
          state_d = S_ISSUE;
        end
        S_ISSUE: if (bus.tile_ready) state_d = S_WAIT;
        S_WAIT:  if (bus.tile_done_i) state_d = S_NEXT;
        S_NEXT: if (last_row && last_col) begin
          done_pulse = 1'b1;
          state_d    = S_IDLE;
        end else begin
          adv_col = ~last_col;
          adv_row = last_col;
          state_d = S_ISSUE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Active job and tile address accumulators, walked row-major with columns fastest
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      job_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      row_c_q <= '0;
      rem_m_q <= '0;
      rem_p_q <= '0;
    end else if (pop) begin
      job_q <= fifo_mem[rd_ptr_q];
    end else if (load) begin
      a_q     <= job_q.base_a;
      b_q     <= job_q.base_b;
      c_q     <= job_q.base_c;
      row_c_q <= job_q.base_c;
      rem_m_q <= job_q.m;
      rem_p_q <= job_q.p;
    end else if (adv_col) begin
      b_q     <= b_q + B_COL_STEP;
      c_q     <= c_q + C_COL_STEP;
      rem_p_q <= rem_p_q - TILE_W;
    end else if (adv_row) begin
      a_q     <= a_q + a_row_step;
      b_q     <= job_q.base_b;
      c_q     <= row_c_q + c_row_step;
      row_c_q <= row_c_q + c_row_step;
      rem_m_q <= rem_m_q - TILE_H;
      rem_p_q <= job_q.p;
    end
  end

  assign bus.cmd_ready   = ~full;
  assign bus.tile_valid  = (state_q == S_ISSUE);
  assign bus.tile_a_addr = a_q;
  assign bus.tile_b_addr = b_q;
  assign bus.tile_c_addr = c_q;
  assign bus.tile_rows   = last_row ? rem_m_q : TILE_H;
  assign bus.tile_cols   = last_col ? rem_p_q : TILE_W;
  assign bus.tile_n      = job_q.n;
  assign bus.job_done    = done_pulse;
  assign bus.job_err     = err_pulse;
  assign bus.job_id_o    = job_q.id;
  assign bus.busy        = (state_q != S_IDLE) | ~empty;
  assign bus.queued      = count_q;
endmodule

// File: tb/tb_matmul_tile_scheduler.sv
// Self-checking bench: directed scenarios plus random jobs against a tile-list reference model.
// Latency: checks the push-to-tile_valid delay and post-abort state.
// Backpressure: exercises a full job FIFO and stalled tile_ready with hold checks.
`timescale 1ns/1ps
module tb_matmul_tile_scheduler;
  localparam int AW = 32, AH = 4, DWB = 1, ADDR_W = 16, DIM_W = 16, DEPTH = 4, ID_W = 4;

  typedef struct packed {
    logic [15:0] a, b, c, rows, cols, n;
  } tile_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  matmul_tile_scheduler_if #(.ADDR_WIDTH(ADDR_W), .DIM_WIDTH(DIM_W), .ID_WIDTH(ID_W),
                             .JOB_FIFO_DEPTH(DEPTH)) bus ();

  matmul_tile_scheduler #(
    .ARRAY_WIDTH(AW), .ARRAY_HEIGHT(AH), .DATA_WIDTH_BYTES(DWB), .ADDR_WIDTH(ADDR_W),
    .DIM_WIDTH(DIM_W), .JOB_FIFO_DEPTH(DEPTH), .ID_WIDTH(ID_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  tile_t           exp_tiles[$];
  logic [ID_W:0]   exp_evts[$];   // {is_err, id}
  tile_t           seen_tiles[$];
  int              n_checks = 0, n_errs = 0;
  int              hs_count = 0, hs_last = 0, valid_cycles = 0;
  int              done_req = 0, done_ack = 0, done_cnt = 0, done_delay = 0;
  bit              auto_ready = 0, manual_ready = 0, done_auto = 0;
  bit              stall_q = 0;
  tile_t           cur_tile, held_tile;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: full ordered tile list and completion event for one job
  task automatic model_job(input logic [ID_W-1:0] id, input int m, n, p, ba, bb, bc);
    if (m == 0 || n == 0 || p == 0) begin
      exp_evts.push_back({1'b1, id});
      return;
    end
    for (int r = 0; r * AH < m; r++) begin
      for (int c = 0; c * AW < p; c++) begin
        tile_t t;
        t.a    = 16'(ba + r * AH * n * DWB);
        t.b    = 16'(bb + c * AW * DWB);
        t.c    = 16'(bc + (r * AH * p + c * AW) * 2 * DWB);
        t.rows = 16'(((m - r * AH) < AH) ? (m - r * AH) : AH);
        t.cols = 16'(((p - c * AW) < AW) ? (p - c * AW) : AW);
        t.n    = 16'(n);
        exp_tiles.push_back(t);
      end
    end
    exp_evts.push_back({1'b0, id});
  endtask

  task automatic set_cmd(input logic [ID_W-1:0] id, input int m, n, p, ba, bb, bc);
    bus.cmd_id = id;
    bus.cmd_m = 16'(m); bus.cmd_n = 16'(n); bus.cmd_p = 16'(p);
    bus.cmd_base_a = 16'(ba); bus.cmd_base_b = 16'(bb); bus.cmd_base_c = 16'(bc);
  endtask

  // Called just after a rising edge; returns just after the accepting edge
  task automatic push_job(input logic [ID_W-1:0] id, input int m, n, p, ba, bb, bc);
    int w = 0;
    set_cmd(id, m, n, p, ba, bb, bc);
    bus.cmd_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.cmd_ready || w > 3000) break;
      w++;
    end
    if (bus.cmd_ready) model_job(id, m, n, p, ba, bb, bc);
    else chk("push_timeout", bus.cmd_ready, 1);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int c = 0;
    do begin
      @(negedge clk);
      c++;
    end while ((bus.busy || exp_evts.size() != 0) && c < 5000);
    chk({tag, "_idle"}, bus.busy, 0);
    chk({tag, "_tiles_left"}, exp_tiles.size(), 0);
    chk({tag, "_evts_left"}, exp_evts.size(), 0);
    @(posedge clk); #1;
  endtask

  // Monitor: tile handshakes, hold-while-stalled, completion events
  always @(negedge clk) begin
    if (reset_n) begin
      cur_tile = {bus.tile_a_addr, bus.tile_b_addr, bus.tile_c_addr,
                  bus.tile_rows, bus.tile_cols, bus.tile_n};
      if (bus.tile_valid) valid_cycles++;
      if (stall_q && bus.tile_valid) chk("tile_hold", cur_tile, held_tile);
      stall_q   = bus.tile_valid && !bus.tile_ready;
      held_tile = cur_tile;
      if (bus.tile_valid && bus.tile_ready) begin
        hs_count++;
        seen_tiles.push_back(cur_tile);
        if (exp_tiles.size() == 0) chk("tile_unexpected", exp_tiles.size(), 1);
        else chk("tile", cur_tile, exp_tiles.pop_front());
      end
      if (bus.job_done || bus.job_err) begin
        chk("done_err_exclusive", bus.job_done & bus.job_err, 0);
        if (exp_evts.size() == 0) chk("evt_unexpected", exp_evts.size(), 1);
        else chk("evt", {bus.job_err, bus.job_id_o}, exp_evts.pop_front());
      end
    end
  end

  // Array-side responder: tile_ready and tile_done_i
  always begin
    @(posedge clk); #1;
    bus.tile_ready  = auto_ready ? ($urandom_range(0, 3) != 0) : manual_ready;
    bus.tile_done_i = 1'b0;
    if (hs_count != hs_last) begin
      hs_last = hs_count;
      if (done_auto) done_cnt = (done_delay > 0) ? done_delay : int'($urandom_range(1, 6));
    end
    if (done_req != done_ack) begin
      done_ack = done_req;
      bus.tile_done_i = 1'b1;
    end else if (done_cnt > 0) begin
      done_cnt--;
      if (done_cnt == 0) bus.tile_done_i = 1'b1;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int b, h0;
    bus.cmd_valid = 1'b0;
    bus.abort_i   = 1'b0;
    set_cmd(0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    chk("rst_tile_valid", bus.tile_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_queued", bus.queued, 0);
    chk("rst_done_err", {bus.job_done, bus.job_err}, 0);
    chk("rst_job_id", bus.job_id_o, 0);
    chk("rst_tile_addr", {bus.tile_a_addr, bus.tile_b_addr, bus.tile_c_addr}, 0);
    chk("rst_tile_dims", {bus.tile_rows, bus.tile_cols}, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Single tile with fixed completion delay and issue latency
    manual_ready = 1; done_auto = 1; done_delay = 10;
    b = seen_tiles.size();
    push_job(4'h5, 4, 8, 32, 'h100, 'h200, 'h300);
    @(negedge clk);
    chk("t1_lat1_valid", bus.tile_valid, 0);
    chk("t1_lat1_busy", bus.busy, 1);
    @(negedge clk);
    chk("t1_lat2_valid", bus.tile_valid, 0);
    @(negedge clk);
    chk("t1_lat3_valid", bus.tile_valid, 1);
    @(posedge clk); #1;
    wait_idle("t1");
    chk("t1_ntiles", seen_tiles.size() - b, 1);

    // Partial tiles, random tile_ready and completion delay
    auto_ready = 1; done_delay = 0;
    b = seen_tiles.size();
    push_job(4'h6, 10, 8, 40, 'h100, 'h200, 'h300);
    wait_idle("t2");
    chk("t2_ntiles", seen_tiles.size() - b, 6);
    if (seen_tiles.size() - b >= 6) begin
      chk("t2_01_b", seen_tiles[b+1].b, 16'h220);
      chk("t2_01_c", seen_tiles[b+1].c, 16'h340);
      chk("t2_01_cols", seen_tiles[b+1].cols, 8);
      chk("t2_10_a", seen_tiles[b+2].a, 16'h120);
      chk("t2_10_c", seen_tiles[b+2].c, 16'h440);
      chk("t2_21_rows", seen_tiles[b+5].rows, 2);
      chk("t2_21_cols", seen_tiles[b+5].cols, 8);
      chk("t2_21_c", seen_tiles[b+5].c, 16'h5C0);
    end

    // Backpressure: array stalled, six back-to-back commands
    auto_ready = 0; manual_ready = 0;
    for (int i = 0; i < 6; i++) begin
      int nn;
      nn = int'($urandom_range(1, 8));
      set_cmd(4'(8 + i), 4, nn, 32, 'h1000 * i, 'h40 * i, 'h800 + i);
      bus.cmd_valid = 1'b1;
      @(negedge clk);
      chk("bp_cmd_ready", bus.cmd_ready, (i < 5));
      if (bus.cmd_ready) model_job(4'(8 + i), 4, nn, 32, 'h1000 * i, 'h40 * i, 'h800 + i);
      @(posedge clk); #1;
    end
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    chk("bp_queued", bus.queued, 4);
    chk("bp_full", bus.cmd_ready, 0);
    repeat (4) @(negedge clk);
    @(posedge clk); #1;
    auto_ready = 1;
    wait_idle("bp");

    // Zero dimension between two valid jobs
    b = seen_tiles.size();
    push_job(4'h2, 4, 4, 32, 'h10, 'h20, 'h30);
    push_job(4'h3, 4, 0, 32, 'h10, 'h20, 'h30);
    push_job(4'h4, 5, 3, 33, 'h40, 'h50, 'h60);
    wait_idle("zero");
    chk("zero_ntiles", seen_tiles.size() - b, 5);

    // Abort during WAIT of tile 2 with two jobs queued
    auto_ready = 0; done_auto = 0; manual_ready = 1;
    h0 = hs_count;
    push_job(4'h7, 10, 8, 40, 'h100, 'h200, 'h300);
    push_job(4'h8, 4, 8, 32, 0, 0, 0);
    push_job(4'h9, 4, 8, 32, 0, 0, 0);
    for (int c = 0; c < 200 && hs_count < h0 + 1; c++) @(negedge clk);
    chk("ab_hs1", hs_count, h0 + 1);
    manual_ready = 0;
    done_req++;
    @(negedge clk);
    manual_ready = 1;
    for (int c = 0; c < 200 && hs_count < h0 + 2; c++) @(negedge clk);
    chk("ab_hs2", hs_count, h0 + 2);
    @(negedge clk);
    chk("ab_pre_queued", bus.queued, 2);
    chk("ab_pre_busy", bus.busy, 1);
    bus.abort_i = 1'b1;
    set_cmd(4'hA, 4, 8, 32, 0, 0, 0);
    bus.cmd_valid = 1'b1;
    @(posedge clk); #1;
    bus.abort_i = 1'b0;
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    chk("ab_busy", bus.busy, 0);
    chk("ab_queued", bus.queued, 0);
    chk("ab_tile_valid", bus.tile_valid, 0);
    chk("ab_job_done", bus.job_done, 0);
    exp_tiles.delete();
    exp_evts.delete();
    b = valid_cycles;
    done_req++;
    repeat (12) @(negedge clk);
    chk("ab_no_tiles", valid_cycles - b, 0);
    chk("ab_still_idle", {bus.busy, bus.queued}, 0);
    @(posedge clk); #1;

    // Address wrap on C
    auto_ready = 1; done_auto = 1; done_delay = 0;
    b = seen_tiles.size();
    push_job(4'h1, 8, 4, 32, 'h0, 'h0, 'hFFF0);
    wait_idle("wrap");
    chk("wrap_ntiles", seen_tiles.size() - b, 2);
    if (seen_tiles.size() - b >= 2) chk("wrap_c", seen_tiles[b+1].c, 16'h00F0);

    // Random jobs
    for (int j = 0; j < 30; j++) begin
      int g;
      g = int'($urandom_range(0, 3));
      repeat (g) begin
        @(posedge clk); #1;
      end
      push_job(4'($urandom_range(0, 15)), int'($urandom_range(0, 13)),
               int'($urandom_range(0, 9)), int'($urandom_range(0, 70)),
               int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)),
               int'($urandom_range(0, 65535)));
    end
    wait_idle("rand");

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule
